// File: rtl/viterbi_pkg.sv
// Shared definitions for the K=3, 4-state Viterbi decoder: trellis state codes,
// the packed survivor column layout and the survivor memory FSM states.
package viterbi_pkg;

    localparam int NUM_STATES = 4;

    localparam logic [1:0] S00 = 2'b00;
    localparam logic [1:0] S01 = 2'b01;
    localparam logic [1:0] S10 = 2'b10;
    localparam logic [1:0] S11 = 2'b11;

    // One column of survivor decisions, packed as {st_11, st_01, st_10, st_00}
    typedef struct packed {
        logic [1:0] st_11;
        logic [1:0] st_01;
        logic [1:0] st_10;
        logic [1:0] st_00;
    } column_t;

    typedef enum logic [1:0] {
        FILL      = 2'd0,
        SELECT    = 2'd1,
        TRACE     = 2'd2,
        WAIT_DONE = 2'd3
    } spmState_e;

    // Builds a column word from the four per-state predecessor decisions
    function automatic column_t pack_column(
        input logic [1:0] st00,
        input logic [1:0] st10,
        input logic [1:0] st01,
        input logic [1:0] st11
    );
        column_t col;
        col.st_00 = st00;
        col.st_10 = st10;
        col.st_01 = st01;
        col.st_11 = st11;
        return col;
    endfunction

endpackage

// File: rtl/survivor_path_memory_if.sv
// Bus between the ACS stage, the survivor path memory and the traceback stage.
// The master side is the surrounding decoder; the slave side is the memory.
interface survivor_path_memory_if #(
    parameter int PM_W = 8
);

    logic            i_valid;
    logic [1:0]      i_prv_st_00;
    logic [1:0]      i_prv_st_10;
    logic [1:0]      i_prv_st_01;
    logic [1:0]      i_prv_st_11;
    logic [PM_W-1:0] i_pm_00;
    logic [PM_W-1:0] i_pm_10;
    logic [PM_W-1:0] i_pm_01;
    logic [PM_W-1:0] i_pm_11;
    logic            i_done_traceback;

    logic            o_ready;
    logic [1:0]      o_select_node;
    logic [1:0]      o_bck_prv_st_00;
    logic [1:0]      o_bck_prv_st_10;
    logic [1:0]      o_bck_prv_st_01;
    logic [1:0]      o_bck_prv_st_11;
    logic            o_en_traceback;

    modport master (
        output i_valid, i_prv_st_00, i_prv_st_10, i_prv_st_01, i_prv_st_11,
        output i_pm_00, i_pm_10, i_pm_01, i_pm_11, i_done_traceback,
        input  o_ready, o_select_node, o_en_traceback,
        input  o_bck_prv_st_00, o_bck_prv_st_10, o_bck_prv_st_01, o_bck_prv_st_11
    );

    modport slave (
        input  i_valid, i_prv_st_00, i_prv_st_10, i_prv_st_01, i_prv_st_11,
        input  i_pm_00, i_pm_10, i_pm_01, i_pm_11, i_done_traceback,
        output o_ready, o_select_node, o_en_traceback,
        output o_bck_prv_st_00, o_bck_prv_st_10, o_bck_prv_st_01, o_bck_prv_st_11
    );

endinterface

// File: rtl/min_state_select.sv
// Combinational 4-way unsigned argmin over path metrics. Ties resolve to the
// lowest state code (00 > 01 > 10 > 11). Shared with the ACS normalisation logic.
module min_state_select
    import viterbi_pkg::*;
#(
    parameter int PM_W = 8
) (
    input  logic [PM_W-1:0] pm00_i,
    input  logic [PM_W-1:0] pm10_i,
    input  logic [PM_W-1:0] pm01_i,
    input  logic [PM_W-1:0] pm11_i,
    output logic [1:0]      minState_o
);

    logic [PM_W-1:0] pmByCode [NUM_STATES];
    logic [PM_W-1:0] bestPm;

    // Lay the metrics out by state code and scan upward with a strict compare,
    // so an equal metric never displaces a lower code already chosen
    always_comb begin
        pmByCode[S00] = pm00_i;
        pmByCode[S01] = pm01_i;
        pmByCode[S10] = pm10_i;
        pmByCode[S11] = pm11_i;
        minState_o    = S00;
        bestPm        = pmByCode[S00];
        for (int i = 1; i < NUM_STATES; i++) begin
            if (pmByCode[i] < bestPm) begin
                bestPm     = pmByCode[i];
                minState_o = 2'(i);
            end
        end
    end

endmodule

// File: rtl/survivor_path_memory.sv
// Survivor path memory: stores DEPTH columns of ACS decisions, picks the
// minimum-metric end state, then replays the columns newest-first to the
// traceback stage until it reports done.
module survivor_path_memory
    import viterbi_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PM_W  = 8,
    parameter int AW    = 4
) (
    input logic                   clk,
    input logic                   rst,
    survivor_path_memory_if.slave bus
);

    spmState_e       state_q;
    logic [AW-1:0]   wrPtr_q;
    logic [AW-1:0]   rdPtr_q;
    logic            ready_q;
    logic            enTraceback_q;
    logic [1:0]      selectNode_q;
    logic [PM_W-1:0] pmLast00_q;
    logic [PM_W-1:0] pmLast10_q;
    logic [PM_W-1:0] pmLast01_q;
    logic [PM_W-1:0] pmLast11_q;
    column_t         mem_q [DEPTH];

    column_t         wrCol_d;
    column_t         rdCol_d;
    logic [1:0]      minState_d;
    logic            accept_d;
    logic            lastCol_d;

    assign wrCol_d   = pack_column(bus.i_prv_st_00, bus.i_prv_st_10,
                                   bus.i_prv_st_01, bus.i_prv_st_11);
    assign accept_d  = (state_q == FILL) && ready_q && bus.i_valid && !rst;
    assign lastCol_d = (wrPtr_q == AW'(DEPTH - 1));

    min_state_select #(
        .PM_W (PM_W)
    ) uMinSelect (
        .pm00_i     (pmLast00_q),
        .pm10_i     (pmLast10_q),
        .pm01_i     (pmLast01_q),
        .pm11_i     (pmLast11_q),
        .minState_o (minState_d)
    );

    // Column storage is written only on an accepted FILL column and is never cleared
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (accept_d && (wrPtr_q == AW'(i))) begin
                mem_q[i] <= wrCol_d;
            end
        end
    end

    // The metrics that arrive with the final column of a block decide the end state
    always_ff @(posedge clk) begin
        if (accept_d && lastCol_d) begin
            pmLast00_q <= bus.i_pm_00;
            pmLast10_q <= bus.i_pm_10;
            pmLast01_q <= bus.i_pm_01;
            pmLast11_q <= bus.i_pm_11;
        end
    end

    // Read mux for the replay pointer; a loop compare keeps any DEPTH up to 2^AW legal
    always_comb begin
        rdCol_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rdPtr_q == AW'(i)) begin
                rdCol_d = mem_q[i];
            end
        end
    end

    // Block sequencer: fill, pick the start node, then replay with the enable raised
    // one cycle after the start node settles; the replay pointer parks on column 0
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FILL;
            wrPtr_q       <= '0;
            rdPtr_q       <= '0;
            ready_q       <= 1'b0;
            enTraceback_q <= 1'b0;
            selectNode_q  <= S00;
        end else begin
            case (state_q)
                FILL: begin
                    ready_q       <= 1'b1;
                    enTraceback_q <= 1'b0;
                    if (accept_d) begin
                        wrPtr_q <= wrPtr_q + 1'b1;
                        if (lastCol_d) begin
                            ready_q <= 1'b0;
                            state_q <= SELECT;
                        end
                    end
                end
                SELECT: begin
                    ready_q      <= 1'b0;
                    selectNode_q <= minState_d;
                    rdPtr_q      <= AW'(DEPTH - 1);
                    state_q      <= TRACE;
                end
                TRACE: begin
                    enTraceback_q <= 1'b1;
                    if (enTraceback_q && (rdPtr_q != '0)) begin
                        rdPtr_q <= rdPtr_q - 1'b1;
                    end
                    if (bus.i_done_traceback) begin
                        enTraceback_q <= 1'b0;
                        ready_q       <= 1'b1;
                        wrPtr_q       <= '0;
                        state_q       <= FILL;
                    end
                end
                default: begin
                    ready_q       <= 1'b0;
                    enTraceback_q <= 1'b0;
                    state_q       <= FILL;
                end
            endcase
        end
    end

    assign bus.o_ready         = ready_q;
    assign bus.o_select_node   = selectNode_q;
    assign bus.o_en_traceback  = enTraceback_q;
    assign bus.o_bck_prv_st_00 = enTraceback_q ? rdCol_d.st_00 : S00;
    assign bus.o_bck_prv_st_10 = enTraceback_q ? rdCol_d.st_10 : S00;
    assign bus.o_bck_prv_st_01 = enTraceback_q ? rdCol_d.st_01 : S00;
    assign bus.o_bck_prv_st_11 = enTraceback_q ? rdCol_d.st_11 : S00;

endmodule

// File: tb/tb_survivor_path_memory.sv
// Scoreboard bench for survivor_path_memory: a driver feeds columns and mimics
// the traceback stage, a reference model queues the expected replay for every
// completed block, and a monitor pops and compares whenever the enable is high.
module tb_survivor_path_memory;

    localparam int DEPTH    = 8;
    localparam int PM_W     = 8;
    localparam int AW       = 4;
    localparam int BUDGET   = 200;
    localparam int PH_RESET = 0;
    localparam int PH_FILL  = 1;
    localparam int PH_BUSY  = 2;

    logic clk;
    logic rst;

    survivor_path_memory_if #(.PM_W(PM_W)) bus ();

    survivor_path_memory #(
        .DEPTH (DEPTH),
        .PM_W  (PM_W),
        .AW    (AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         compareCount  = 0;
    int         mismatchCount = 0;
    int         phase         = PH_RESET;
    int         enCount       = 0;
    int         latCnt        = 0;
    bit         rstCheck      = 0;
    bit         toggleBit     = 0;
    logic [1:0] expSel        = 2'b00;
    logic [7:0] blockCols [$];
    logic [9:0] expQueue [$];

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the driver itself gets stuck
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Start node from the metrics: the smallest value, first state code that has it
    function automatic logic [1:0] refArgmin(input int pm [4]);
        int minVal;
        minVal = pm[0];
        for (int s = 1; s < 4; s++) begin
            if (pm[s] < minVal) minVal = pm[s];
        end
        for (int s = 0; s < 4; s++) begin
            if (pm[s] == minVal) return 2'(s);
        end
        return 2'b00;
    endfunction

    // Monitor: every enabled cycle must match the next queued replay entry
    always @(negedge clk) begin
        if (bus.o_en_traceback === 1'b1) begin
            if (expQueue.size() == 0) begin
                compareCount++;
                mismatchCount++;
                $display("[TB] FAIL unexpected_enable: got enable with no block pending, expected enable low");
            end else begin
                checkOutput("replay", 32'({bus.o_select_node, bus.o_bck_prv_st_11, bus.o_bck_prv_st_01,
                                          bus.o_bck_prv_st_10, bus.o_bck_prv_st_00}),
                            32'(expQueue.pop_front()));
            end
        end
    end

    // Runs one block. mode: 0 random, 1 zero decisions with metrics 3/9/7/5,
    // 2 st_01 = column index, 3 all metrics 4, 4 metrics 6/2/2/6.
    // validMode: 0 random, 1 held high, 2 toggling.
    task automatic applyStimulus(input int mode, input int validMode, input bit rstInTrace);
        int         cycles;
        bit         finished;
        bit         v;
        int         nextPhase;
        logic [1:0] st [4];
        int         pm [4];
        cycles   = 0;
        finished = 0;
        while (!finished) begin
            @(negedge clk);
            #1;
            cycles++;
            checkOutput("o_ready", 32'(bus.o_ready), 32'(phase == PH_FILL));
            if (rstCheck) begin
                checkOutput("en_after_rst", 32'(bus.o_en_traceback), 32'd0);
                checkOutput("select_after_rst", 32'(bus.o_select_node), 32'd0);
                checkOutput("bck_after_rst", 32'({bus.o_bck_prv_st_11, bus.o_bck_prv_st_01,
                                                  bus.o_bck_prv_st_10, bus.o_bck_prv_st_00}), 32'd0);
                rstCheck = 0;
            end
            case (latCnt)
                1: begin
                    checkOutput("en_at_select", 32'(bus.o_en_traceback), 32'd0);
                    latCnt = 2;
                end
                2: begin
                    checkOutput("select_node", 32'(bus.o_select_node), 32'(expSel));
                    checkOutput("en_before_trace", 32'(bus.o_en_traceback), 32'd0);
                    latCnt = 3;
                end
                3: begin
                    checkOutput("en_rise", 32'(bus.o_en_traceback), 32'd1);
                    latCnt = 0;
                end
                default: ;
            endcase
            if (phase == PH_BUSY && bus.o_en_traceback === 1'b1) enCount++;

            rst                  = 1'b0;
            bus.i_done_traceback = 1'b0;
            case (validMode)
                1:       v = 1'b1;
                2:       begin v = toggleBit; toggleBit = !toggleBit; end
                default: v = ($urandom_range(9) < 7);
            endcase
            for (int s = 0; s < 4; s++) begin
                st[s] = 2'($urandom_range(3));
                pm[s] = int'($urandom_range(255));
            end
            case (mode)
                1: begin
                    for (int s = 0; s < 4; s++) st[s] = 2'b00;
                    pm[0] = 3; pm[2] = 9; pm[1] = 7; pm[3] = 5;
                end
                2: st[1] = 2'(blockCols.size());
                3: for (int s = 0; s < 4; s++) pm[s] = 4;
                4: begin pm[0] = 6; pm[2] = 2; pm[1] = 2; pm[3] = 6; end
                default: ;
            endcase
            bus.i_valid     = v;
            bus.i_prv_st_00 = st[0];
            bus.i_prv_st_01 = st[1];
            bus.i_prv_st_10 = st[2];
            bus.i_prv_st_11 = st[3];
            bus.i_pm_00     = PM_W'(pm[0]);
            bus.i_pm_01     = PM_W'(pm[1]);
            bus.i_pm_10     = PM_W'(pm[2]);
            bus.i_pm_11     = PM_W'(pm[3]);

            nextPhase = phase;
            if (phase == PH_RESET) begin
                nextPhase = PH_FILL;
            end else if (phase == PH_FILL) begin
                if (v) begin
                    blockCols.push_back({st[3], st[1], st[2], st[0]});
                    if (blockCols.size() == DEPTH) begin
                        expSel = refArgmin(pm);
                        for (int k = DEPTH - 1; k >= 0; k--) expQueue.push_back({expSel, blockCols[k]});
                        expQueue.push_back({expSel, blockCols[0]});
                        blockCols.delete();
                        latCnt    = 1;
                        nextPhase = PH_BUSY;
                    end
                end
                if (mode == 0 && $urandom_range(7) == 0) bus.i_done_traceback = 1'b1;
            end else begin
                if (rstInTrace && bus.o_en_traceback === 1'b1 && enCount == 3) begin
                    rst = 1'b1;
                    expQueue.delete();
                    enCount   = 0;
                    latCnt    = 0;
                    rstCheck  = 1;
                    nextPhase = PH_RESET;
                    finished  = 1;
                end else if (enCount == DEPTH + 1) begin
                    bus.i_done_traceback = 1'b1;
                    enCount   = 0;
                    nextPhase = PH_FILL;
                    finished  = 1;
                end
            end
            phase = nextPhase;

            if (!finished && cycles >= BUDGET) begin
                compareCount++;
                mismatchCount++;
                $display("[TB] FAIL block_timeout: got no traceback completion in %0d cycles, expected completion", cycles);
                finished = 1;
            end
        end
    endtask

    // Main sequence: reset, the directed blocks, a mid-trace reset, then random blocks
    initial begin
        rst                  = 1'b1;
        bus.i_valid          = 1'b0;
        bus.i_prv_st_00      = 2'b00;
        bus.i_prv_st_10      = 2'b00;
        bus.i_prv_st_01      = 2'b00;
        bus.i_prv_st_11      = 2'b00;
        bus.i_pm_00          = '0;
        bus.i_pm_10          = '0;
        bus.i_pm_01          = '0;
        bus.i_pm_11          = '0;
        bus.i_done_traceback = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_ready", 32'(bus.o_ready), 32'd0);
        checkOutput("reset_en", 32'(bus.o_en_traceback), 32'd0);
        checkOutput("reset_select", 32'(bus.o_select_node), 32'd0);
        checkOutput("reset_bck", 32'({bus.o_bck_prv_st_11, bus.o_bck_prv_st_01,
                                      bus.o_bck_prv_st_10, bus.o_bck_prv_st_00}), 32'd0);
        rst   = 1'b0;
        phase = PH_FILL;

        applyStimulus(1, 1, 1'b0);
        applyStimulus(2, 0, 1'b0);
        applyStimulus(3, 1, 1'b0);
        applyStimulus(4, 2, 1'b0);
        applyStimulus(0, 1, 1'b1);
        applyStimulus(0, 0, 1'b0);
        for (int b = 0; b < 8; b++) begin
            applyStimulus(0, int'($urandom_range(2)), 1'b0);
        end

        @(negedge clk);
        #1;
        bus.i_done_traceback = 1'b0;
        checkOutput("ready_after_done", 32'(bus.o_ready), 32'(phase == PH_FILL));
        checkOutput("queue_drained", 32'(expQueue.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
